// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive peripheral.
// Provides the receiver FSM state type, status-register bit positions and
// the character width used by the core and the bus-facing top.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam int unsigned RX_VALID_BIT     = 0;
  localparam int unsigned RX_OVERRUN_BIT   = 1;
  localparam int unsigned RX_FRAME_ERR_BIT = 2;
  localparam int unsigned RX_STATUS_W      = 3;

  localparam int unsigned UART_DATA_BITS   = 8;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: synchronizer, framing FSM, bit counters, shift register.
// Ports:
//   clk_i, reset_i  : system clock, synchronous active-high reset
//   uart_rx_i       : asynchronous serial line, idle high
//   byte_done_o     : 1-cycle pulse in the stop-sample cycle of a good frame
//   byte_o          : received character, valid while byte_done_o is high
//   frame_err_o     : 1-cycle pulse in the stop-sample cycle of a bad stop bit
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      uart_rx_i,
  output logic                      byte_done_o,
  output logic [UART_DATA_BITS-1:0] byte_o,
  output logic                      frame_err_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT     = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      rx_meta_q, rx_s_q;

  // Two-flop synchronizer plus FSM state; sync flops reset to line-idle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Framing FSM: start is re-checked at half a bit, then every bit is
  // sampled a full bit period later, landing mid-bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_done_o = 1'b0;
    frame_err_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          shift_d   = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_done_o = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            frame_err_o = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A held-low (break) line must not look like a fresh start bit.
      ST_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/peri_uart_rx.sv
// Memory-mapped UART receiver peripheral.
// Ports:
//   clk_i, reset_i   : system clock, synchronous active-high reset
//   uart_rx_i        : serial line input, idle high
//   data_i           : bus write data, bits [2:0] load the status register
//   we_ctrl_uart_i   : status register write enable
//   data_out_rx_o    : {24'b0, rx_data}
//   data_out_ctrl_o  : {29'b0, frame_err, overrun, rx_valid}
module peri_uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        uart_rx_i,
  input  logic [31:0] data_i,
  input  logic        we_ctrl_uart_i,
  output logic [31:0] data_out_rx_o,
  output logic [31:0] data_out_ctrl_o
);

  logic                      byte_done;
  logic [UART_DATA_BITS-1:0] byte_rx;
  logic                      frame_err;

  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic [RX_STATUS_W-1:0]    status_q, status_d;

  logic unused_data;
  assign unused_data = ^data_i[31:RX_STATUS_W];

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .uart_rx_i   (uart_rx_i),
    .byte_done_o (byte_done),
    .byte_o      (byte_rx),
    .frame_err_o (frame_err)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_data_q <= '0;
      status_q  <= '0;
    end else begin
      rx_data_q <= rx_data_d;
      status_q  <= status_d;
    end
  end

  // Software write first, hardware sets applied on top so they win.
  always_comb begin
    rx_data_d = rx_data_q;
    status_d  = status_q;

    if (we_ctrl_uart_i) begin
      status_d = data_i[RX_STATUS_W-1:0];
    end

    if (byte_done) begin
      rx_data_d              = byte_rx;
      status_d[RX_VALID_BIT] = 1'b1;
      if (status_q[RX_VALID_BIT]) begin
        status_d[RX_OVERRUN_BIT] = 1'b1;
      end
    end

    if (frame_err) begin
      status_d[RX_FRAME_ERR_BIT] = 1'b1;
    end
  end

  assign data_out_rx_o   = 32'(rx_data_q);
  assign data_out_ctrl_o = 32'(status_q);

endmodule
